// File: rtl/map_pkg.sv
// Shared constants and types for the tile-map colour RAM and its arbiter.
// Contents: map geometry, 4:4:4 colour constants, game request opcodes, arbiter FSM states.
// Imported by map_ram_arbiter; holds no logic of its own.
package map_pkg;

   localparam int ADDR_W      = 14;
   localparam int DATA_W      = 12;
   localparam int MAP_DEPTH   = 16200;   // 300 tiles x 54 rows
   localparam int MAP_W_TILES = 300;
   localparam int TILE_SHIFT  = 4;
   localparam int CNT_W       = 8;

   localparam logic [11:0] SKY_COL  = 12'h2CD;
   localparam logic [11:0] COIN_COL = 12'hDD2;
   localparam logic [11:0] POLE_COL = 12'hF0E;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_CLEAR = 2'b10,   // atomic clear-coin read-modify-write
      OP_RSVD  = 2'b11
   } req_op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_CHECK,
      ST_WRITE,
      ST_RESP
   } arb_state_t;

endpackage

// File: rtl/map_ram_arbiter.sv
// Single-port map RAM arbiter: render reads win every cycle, one game transaction (read/write/clear-coin) at a time.
// Latency (no stalls, accept at T): read T+3, write T+2, clear miss T+3, clear hit T+4, error T+1; +1 per render stall.
// Backpressure: req_ready only in IDLE; game accesses stall while render_en=1 (no timeout, blanking bounds the wait).
// Ports: render_en/addr/data (video path), req_*/rsp_* (game path), clr_stats/coin_total, ram_* (SRAM, 1-cycle read).
module map_ram_arbiter
   import map_pkg::*;
#(
   parameter int                 ADDR_W    = map_pkg::ADDR_W,
   parameter int                 DATA_W    = map_pkg::DATA_W,
   parameter int                 MAP_DEPTH = map_pkg::MAP_DEPTH,
   parameter logic [DATA_W-1:0]  COIN_COL  = DATA_W'(map_pkg::COIN_COL),
   parameter logic [DATA_W-1:0]  SKY_COL   = DATA_W'(map_pkg::SKY_COL),
   parameter int                 CNT_W     = map_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              render_en,
   input  logic [ADDR_W-1:0] render_addr,
   output logic [DATA_W-1:0] render_data,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_hit,
   output logic              rsp_err,
   input  logic              clr_stats,
   output logic [CNT_W-1:0]  coin_total,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   arb_state_t        state;
   req_op_t           op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              fsm_access;
   logic              coin_inc;

   // The game side only touches the port in ISSUE/WRITE and only when render lets go.
   assign fsm_access  = !render_en && (state == ST_ISSUE || state == ST_WRITE);
   assign ram_addr    = fsm_access ? addr_q : render_addr;
   assign ram_write   = !render_en && (state == ST_WRITE);
   assign ram_wdata   = wdata_q;
   assign render_data = ram_rdata;
   assign req_ready   = (state == ST_IDLE);

   // A coin is counted when its SKY_COL overwrite actually reaches the RAM.
   assign coin_inc = ram_write && (op_q == OP_CLEAR);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         op_q      <= OP_READ;
         addr_q    <= '0;
         wdata_q   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_hit   <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op_t'(req_op);
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  if (req_addr >= ADDR_W'(MAP_DEPTH) || req_op == OP_RSVD) begin
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                     state     <= ST_RESP;
                  end else if (req_op == OP_WRITE) begin
                     state <= ST_WRITE;
                  end else begin
                     state <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (!render_en) state <= ST_CHECK;
            end
            ST_CHECK: begin
               // Read data returned for the address presented in ISSUE.
               rsp_data <= ram_rdata;
               if (op_q == OP_CLEAR && ram_rdata == COIN_COL) begin
                  wdata_q <= SKY_COL;
                  rsp_hit <= 1'b1;
                  state   <= ST_WRITE;
               end else begin
                  rsp_valid <= 1'b1;
                  state     <= ST_RESP;
               end
            end
            ST_WRITE: begin
               if (!render_en) begin
                  rsp_valid <= 1'b1;
                  state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               // Response fields read as zero outside the pulse.
               rsp_data <= '0;
               rsp_hit  <= 1'b0;
               rsp_err  <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Saturating coin counter; a coincident clear takes precedence.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         coin_total <= '0;
      end else if (clr_stats) begin
         coin_total <= '0;
      end else if (coin_inc && coin_total != '1) begin
         coin_total <= coin_total + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_map_ram_arbiter.sv
// Directed self-checking bench for map_ram_arbiter with a 1-cycle registered SRAM model.
// Inputs driven #1 after posedge, outputs sampled at negedge.
// Scenarios: reset, read, write, clear-coin, render priority, range error, counter saturation, async reset.
module tb_map_ram_arbiter;

   logic        clk;
   logic        rst;
   logic        render_en;
   logic [13:0] render_addr;
   logic [11:0] render_data;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [13:0] req_addr;
   logic [11:0] req_wdata;
   logic        rsp_valid;
   logic [11:0] rsp_data;
   logic        rsp_hit;
   logic        rsp_err;
   logic        clr_stats;
   logic [7:0]  coin_total;
   logic [13:0] ram_addr;
   logic        ram_write;
   logic [11:0] ram_wdata;
   logic [11:0] ram_rdata;

   logic [11:0] mem [0:16383];
   logic        pl_en;
   logic [13:0] pl_addr;
   logic [11:0] pl_data;

   int n_cmp;
   int n_fail;

   map_ram_arbiter dut (
      .clk(clk), .rst(rst),
      .render_en(render_en), .render_addr(render_addr), .render_data(render_data),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
      .clr_stats(clr_stats), .coin_total(coin_total),
      .ram_addr(ram_addr), .ram_write(ram_write), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: registered read, write-first not needed (arbiter never reads and writes the same cycle).
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (ram_write) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic preload(input logic [13:0] a, input logic [11:0] d);
      @(posedge clk); #1;
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   // Issues one request at cycle T and waits for the response pulse.
   // lat = cycles from T to rsp_valid (-1 on timeout); wr_n/wr_d = first write cycle/data; wr_cnt = writes seen.
   task automatic do_req(input logic [1:0] op, input logic [13:0] a, input logic [11:0] wd,
                         output int lat, output logic [11:0] d, output logic h, output logic e,
                         output logic rdy0, output int wr_n, output logic [11:0] wr_d, output int wr_cnt);
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
      @(negedge clk);
      rdy0 = req_ready;
      lat = -1; wr_n = -1; wr_d = '0; wr_cnt = 0; d = '0; h = 1'b0; e = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
         @(negedge clk);
         if (ram_write) begin
            if (wr_n < 0) begin wr_n = n; wr_d = ram_wdata; end
            wr_cnt++;
         end
         if (rsp_valid) begin
            lat = n; d = rsp_data; h = rsp_hit; e = rsp_err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      n_cmp++; if ({rsp_data, rsp_hit, rsp_err} !== 14'h0) begin n_fail++; $display("FAIL reset_rsp got %h/%b/%b want 0", rsp_data, rsp_hit, rsp_err); end
      n_cmp++; if (coin_total !== 8'd0) begin n_fail++; $display("FAIL reset_coin got %0d want 0", coin_total); end
      n_cmp++; if (ram_write !== 1'b0) begin n_fail++; $display("FAIL reset_ram_write got %b want 0", ram_write); end
   endtask

   task automatic test_read();
      int lat, wn, wc; logic [11:0] d, wdd; logic h, e, r;
      preload(14'd100, 12'h2CD);
      do_req(2'b00, 14'd100, 12'h000, lat, d, h, e, r, wn, wdd, wc);
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL read_latency got %0d want 3", lat); end
      n_cmp++; if (d !== 12'h2CD) begin n_fail++; $display("FAIL read_data got %h want 2cd", d); end
      n_cmp++; if ({h, e} !== 2'b00) begin n_fail++; $display("FAIL read_flags got hit=%b err=%b want 0/0", h, e); end
      n_cmp++; if (wc !== 0) begin n_fail++; $display("FAIL read_no_write got %0d writes want 0", wc); end
   endtask

   task automatic test_write();
      int lat, wn, wc; logic [11:0] d, wdd; logic h, e, r;
      do_req(2'b01, 14'd200, 12'hABC, lat, d, h, e, r, wn, wdd, wc);
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL write_latency got %0d want 2", lat); end
      n_cmp++; if (wn !== 1 || wdd !== 12'hABC) begin n_fail++; $display("FAIL write_pulse got cyc %0d data %h want 1/abc", wn, wdd); end
      n_cmp++; if ({d, h, e} !== 14'h0) begin n_fail++; $display("FAIL write_rsp got %h/%b/%b want 0", d, h, e); end
      n_cmp++; if (mem[200] !== 12'hABC) begin n_fail++; $display("FAIL write_mem got %h want abc", mem[200]); end
      do_req(2'b00, 14'd200, 12'h000, lat, d, h, e, r, wn, wdd, wc);
      n_cmp++; if (lat !== 3 || d !== 12'hABC) begin n_fail++; $display("FAIL write_readback got lat %0d data %h want 3/abc", lat, d); end
   endtask

   task automatic test_clear_coin();
      int lat, wn, wc; logic [11:0] d, wdd; logic h, e, r;
      preload(14'd305, 12'hDD2);
      do_req(2'b10, 14'd305, 12'h000, lat, d, h, e, r, wn, wdd, wc);
      n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL clr_hit_latency got %0d want 4", lat); end
      n_cmp++; if (wn !== 3 || wdd !== 12'h2CD) begin n_fail++; $display("FAIL clr_hit_write got cyc %0d data %h want 3/2cd", wn, wdd); end
      n_cmp++; if (h !== 1'b1 || d !== 12'hDD2) begin n_fail++; $display("FAIL clr_hit_rsp got hit %b data %h want 1/dd2", h, d); end
      n_cmp++; if (coin_total !== 8'd1) begin n_fail++; $display("FAIL clr_hit_count got %0d want 1", coin_total); end
      do_req(2'b10, 14'd305, 12'h000, lat, d, h, e, r, wn, wdd, wc);
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL clr_miss_latency got %0d want 3", lat); end
      n_cmp++; if (h !== 1'b0 || d !== 12'h2CD) begin n_fail++; $display("FAIL clr_miss_rsp got hit %b data %h want 0/2cd", h, d); end
      n_cmp++; if (wc !== 0 || coin_total !== 8'd1) begin n_fail++; $display("FAIL clr_miss_side got writes %0d count %0d want 0/1", wc, coin_total); end
   endtask

   task automatic test_render_priority();
      int bad_addr, bad_wr;
      bad_addr = 0; bad_wr = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = 2'b01; req_addr = 14'd400; req_wdata = 12'h123;
      render_en = 1'b1; render_addr = 14'd100;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ram_write !== 1'b0 || rsp_valid !== 1'b0) bad_wr++;
         if (ram_addr !== render_addr) bad_addr++;
         if (i == 1) begin
            n_cmp++; if (render_data !== 12'h2CD) begin n_fail++; $display("FAIL render_data got %h want 2cd", render_data); end
         end
         @(posedge clk); #1;
         req_valid = 1'b0;
         render_addr = 14'(100 + (i + 1) * 3);
      end
      n_cmp++; if (bad_wr !== 0) begin n_fail++; $display("FAIL prio_no_write got %0d bad cycles want 0", bad_wr); end
      n_cmp++; if (bad_addr !== 0) begin n_fail++; $display("FAIL prio_addr_track got %0d bad cycles want 0", bad_addr); end
      render_en = 1'b0;
      @(negedge clk);
      n_cmp++; if (ram_write !== 1'b1 || ram_addr !== 14'd400 || ram_wdata !== 12'h123) begin
         n_fail++; $display("FAIL prio_write got wr %b addr %0d data %h want 1/400/123", ram_write, ram_addr, ram_wdata); end
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 12'h000) begin n_fail++; $display("FAIL prio_rsp got vld %b data %h want 1/000", rsp_valid, rsp_data); end
   endtask

   task automatic test_out_of_range();
      int lat, wn, wc; logic [11:0] d, wdd; logic h, e, r;
      do_req(2'b00, 14'd16200, 12'h000, lat, d, h, e, r, wn, wdd, wc);
      n_cmp++; if (lat !== 1 || e !== 1'b1) begin n_fail++; $display("FAIL range_err got lat %0d err %b want 1/1", lat, e); end
      n_cmp++; if (wc !== 0 || d !== 12'h000) begin n_fail++; $display("FAIL range_side got writes %0d data %h want 0/000", wc, d); end
      do_req(2'b11, 14'd5, 12'h000, lat, d, h, e, r, wn, wdd, wc);
      n_cmp++; if (r !== 1'b1) begin n_fail++; $display("FAIL range_next_ready got %b want 1", r); end
      n_cmp++; if (lat !== 1 || e !== 1'b1 || h !== 1'b0) begin n_fail++; $display("FAIL op11_err got lat %0d err %b hit %b want 1/1/0", lat, e, h); end
   endtask

   task automatic test_counter();
      int lat, wn, wc, misses; logic [11:0] d, wdd; logic h, e, r;
      misses = 0;
      for (int i = 0; i < 254; i++) begin
         preload(14'd500, 12'hDD2);
         do_req(2'b10, 14'd500, 12'h000, lat, d, h, e, r, wn, wdd, wc);
         if (h !== 1'b1) misses++;
      end
      n_cmp++; if (misses !== 0) begin n_fail++; $display("FAIL cnt_hits got %0d misses want 0", misses); end
      n_cmp++; if (coin_total !== 8'd255) begin n_fail++; $display("FAIL cnt_255 got %0d want 255", coin_total); end
      preload(14'd500, 12'hDD2);
      do_req(2'b10, 14'd500, 12'h000, lat, d, h, e, r, wn, wdd, wc);
      n_cmp++; if (coin_total !== 8'd255 || h !== 1'b1) begin n_fail++; $display("FAIL cnt_saturate got %0d hit %b want 255/1", coin_total, h); end
      // Clear exactly in the cycle the hit's write lands.
      preload(14'd500, 12'hDD2);
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = 2'b10; req_addr = 14'd500;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      clr_stats = 1'b1;
      @(negedge clk);
      n_cmp++; if (ram_write !== 1'b1) begin n_fail++; $display("FAIL cnt_clr_align got wr %b want 1", ram_write); end
      @(posedge clk); #1;
      clr_stats = 1'b0;
      @(negedge clk);
      n_cmp++; if (coin_total !== 8'd0 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL cnt_clr_wins got %0d vld %b want 0/1", coin_total, rsp_valid); end
   endtask

   task automatic test_async_reset();
      int wr_seen, rsp_seen;
      wr_seen = 0; rsp_seen = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = 2'b01; req_addr = 14'd600; req_wdata = 12'h456;
      render_en = 1'b1; render_addr = 14'd0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL arst_stalled got ready %b want 0", req_ready); end
      #1;
      rst = 1'b0;
      #1;
      n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL arst_immediate got ready %b vld %b want 1/0", req_ready, rsp_valid); end
      @(posedge clk); #1;
      rst = 1'b1;
      render_en = 1'b0;
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready_after got %b want 1", req_ready); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ram_write === 1'b1) wr_seen++;
         if (rsp_valid === 1'b1) rsp_seen++;
      end
      n_cmp++; if (wr_seen !== 0 || rsp_seen !== 0) begin n_fail++; $display("FAIL arst_abandon got writes %0d rsps %0d want 0/0", wr_seen, rsp_seen); end
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      rst = 1'b0; render_en = 1'b0; render_addr = '0;
      req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wdata = '0;
      clr_stats = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      test_reset();
      test_read();
      test_write();
      test_clear_coin();
      test_render_priority();
      test_out_of_range();
      test_counter();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/map_ram_arbiter.md
Name: map_ram_arbiter

Overview:
- Single-port arbiter/sequencer in front of the tile-map colour SRAM (300 tiles wide × 54 rows = 16200 words × 12 bit, registered read output).
- Gives the VGA render path absolute priority on every pixel clock.
- Serves one game-side transaction at a time (read probe, write, or atomic clear-coin read-modify-write) in cycles where render does not need the port.
- Counts coins removed, so collision/score logic never writes the RAM directly.

Parameters:
ADDR_W, 14, map RAM address width
DATA_W, 12, colour word width (4:4:4 RGB)
MAP_DEPTH, 16200, number of valid words; addresses >= MAP_DEPTH rejected
COIN_COL, 12'hDD2, colour identifying a coin tile
SKY_COL, 12'h2CD, colour written over a cleared coin
CNT_W, 8, coin counter width

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-low reset
render_en  in  1  render needs the RAM this cycle (active video)
render_addr  in  ADDR_W  render read address
render_data  out  DATA_W  ram_rdata passthrough; valid the cycle after render_addr is driven
req_valid  in  1  game request present
req_ready  out  1  arbiter accepts a request (high only in IDLE)
req_op  in  2  00 read, 01 write, 10 clear-coin, 11 reserved (treated as error)
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data (op 01)
rsp_valid  out  1  one-cycle response pulse
rsp_data  out  DATA_W  read data (op 00 / op 10), 0 for write/error
rsp_hit  out  1  op 10 found and cleared a coin
rsp_err  out  1  address out of range or op 11
clr_stats  in  1  synchronous clear of coin_total
coin_total  out  CNT_W  saturating count of coins cleared
ram_addr  out  ADDR_W  to SRAM
ram_write  out  1  to SRAM
ram_wdata  out  DATA_W  to SRAM
ram_rdata  in  DATA_W  from SRAM (registered, 1-cycle latency)

Behaviour:
- Reset (rst=0, async): state IDLE; rsp_* = 0; coin_total = 0; internal request registers = 0.
- Port mux (combinational):
  - render_en=1: ram_addr = render_addr, ram_write = 0.
  - Otherwise the FSM drives the port. With no FSM access, ram_addr = render_addr and ram_write = 0.
  - ram_write is never 1 while render_en=1.
- FSM states: IDLE, ISSUE, CHECK, WRITE, RESP.
  - IDLE: req_ready=1. On req_valid, latch op/addr/wdata.
    - addr >= MAP_DEPTH or op=11 → RESP with err=1.
    - op 01 → WRITE.
    - op 00/10 → ISSUE.
  - ISSUE: if render_en=0, drive ram_addr=latched addr and go to CHECK; otherwise stall in ISSUE.
  - CHECK: capture ram_rdata into rsp_data.
    - op 00 → RESP.
    - op 10 with data==COIN_COL → WRITE with wdata=SKY_COL, hit=1.
    - op 10, data not a coin → RESP with hit=0.
  - WRITE: if render_en=0, ram_write=1 for exactly one cycle, then RESP (op 01 sets rsp_data=0). Otherwise stall in WRITE.
  - RESP: rsp_valid=1 for one cycle with rsp_data/hit/err; then IDLE. A new request can be accepted the following cycle.
- Latency with no render stalls (accept at cycle T):
  - read: rsp at T+3
  - write: rsp at T+2
  - clear-coin miss: rsp at T+3
  - clear-coin hit: rsp at T+4
  - error: rsp at T+1
  - Each stall cycle adds one cycle.
- Atomicity: render only reads, and only one game transaction is outstanding, so a clear-coin RMW cannot be interleaved with another write.
- coin_total increments when the WRITE of a clear-coin hit completes; it saturates at 2^CNT_W-1.
  - clr_stats in the same cycle as an increment: the clear wins → 0.
- Reset mid-transaction: the transaction is abandoned, no write issued, no response.
- Starvation: the bound is the render_en active span. The render path must drop render_en in horizontal/vertical blanking; the arbiter has no timeout.

Decomposition:
- Shared package map_pkg:
  - ADDR_W, DATA_W, MAP_DEPTH, MAP_W_TILES=300, TILE_SHIFT=4
  - colour constants SKY_COL, COIN_COL, POLE_COL=12'hF0E
  - req_op encoding
  - FSM state enum
- No sub-module needed. coin_total saturating counter may be a small inline always block.

Test Plan:
- Read, render idle: preload addr 100 = 12'h2CD; op 00 addr 100 at T → rsp_valid at T+3, rsp_data=12'h2CD, hit=0, err=0.
- Clear-coin hit: addr 305 = 12'hDD2; op 10 → ram_write pulse with ram_wdata=12'h2CD at T+3; rsp at T+4 with hit=1, rsp_data=12'hDD2; coin_total 0→1. Repeat op 10 on 305 → hit=0, rsp_data=12'h2CD, coin_total stays 1.
- Render priority: hold render_en=1 for 20 cycles starting at T with op 01 pending → ram_write stays 0 and ram_addr tracks render_addr. The write occurs in the first cycle with render_en=0; rsp follows one cycle later.
- Out of range: op 00 addr 16200 → rsp at T+1 with err=1; no RAM access; next request accepted at T+2.
- Counter: 255 coin hits → coin_total=255; a further hit keeps 255; clr_stats coincident with a hit → 0.
- Async reset: assert rst=0 while in WRITE stalled by render_en → immediately IDLE, rsp_valid=0, no write after release; req_ready=1 the first cycle after rst=1.
